// File: rtl/clk_ctrl_pkg.sv
// Shared definitions for the buffered-clock gate controller:
// FSM state encoding and the hysteresis counter width helper.
package clk_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t OFF  = 2'd0;
  localparam state_t WAKE = 2'd1;
  localparam state_t ON   = 2'd2;
  localparam state_t IDLE = 2'd3;

  // One counter serves both the wake settle and the idle hysteresis,
  // so it must hold the larger of the two terminal values.
  function automatic int cnt_w(input int wake_cycles, input int idle_cycles);
    int max_cycles;
    max_cycles = (wake_cycles > idle_cycles) ? wake_cycles : idle_cycles;
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/clk_gate_timer.sv
// Loadable down-counter shared by the WAKE settle and IDLE hysteresis phases.
// zero reflects the registered count, so it is glitch-free for the FSM.
module clk_gate_timer #(
  parameter int W = 4
) (
  input  logic         pclock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (load) begin
      cnt_next = value;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_next = cnt_reg - W'(1);
    end
  end

  always_ff @(posedge pclock) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/clk_gate_ctrl.sv
// Sequencing controller for the buffered clock branch: arbitrates requester
// demand, applies a wake settle delay and an idle hysteresis, drives clk_en.
module clk_gate_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 8
) (
  input  logic               pclock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               force_on,
  output logic [NUM_REQ-1:0] ack,
  output logic               clk_en,
  output logic [1:0]         state
);

  localparam int CNT_W = cnt_w(WAKE_CYCLES, IDLE_CYCLES);
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);

  state_t             state_reg;
  state_t             state_next;
  logic               clk_en_reg;
  logic               clk_en_next;
  logic [NUM_REQ-1:0] ack_reg;
  logic [NUM_REQ-1:0] ack_next;

  logic               demand;
  logic               ack_grant;
  logic               tmr_load;
  logic               tmr_dec;
  logic [CNT_W-1:0]   tmr_value;
  logic               tmr_zero;

  assign demand = (|req) | force_on;

  clk_gate_timer #(
    .W (CNT_W)
  ) u_timer (
    .pclock  (pclock),
    .reset_n (reset_n),
    .load    (tmr_load),
    .value   (tmr_value),
    .dec     (tmr_dec),
    .zero    (tmr_zero)
  );

  always_comb begin
    state_next  = state_reg;
    clk_en_next = clk_en_reg;
    ack_grant   = 1'b0;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;
    tmr_value   = WAKE_LOAD;

    case (state_reg)
      OFF: begin
        clk_en_next = 1'b0;
        if (demand) begin
          state_next  = WAKE;
          clk_en_next = 1'b1;
          tmr_load    = 1'b1;
          tmr_value   = WAKE_LOAD;
        end
      end

      // A demand drop here does not abort; ON then falls to IDLE next edge.
      WAKE: begin
        clk_en_next = 1'b1;
        if (tmr_zero) begin
          state_next = ON;
          ack_grant  = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      ON: begin
        clk_en_next = 1'b1;
        if (!demand) begin
          state_next = IDLE;
          tmr_load   = 1'b1;
          tmr_value  = IDLE_LOAD;
        end else begin
          ack_grant = 1'b1;
        end
      end

      // Clock is still running, so a new demand returns to ON without settling.
      IDLE: begin
        clk_en_next = 1'b1;
        if (demand) begin
          state_next = ON;
          ack_grant  = 1'b1;
        end else if (tmr_zero) begin
          state_next  = OFF;
          clk_en_next = 1'b0;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      default: begin
        state_next  = OFF;
        clk_en_next = 1'b0;
      end
    endcase
  end

  // force_on contributes to demand but has no ack bit of its own.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ack
      assign ack_next[gi] = ack_grant & req[gi];
    end
  endgenerate

  always_ff @(posedge pclock) begin
    if (!reset_n) begin
      state_reg  <= OFF;
      clk_en_reg <= 1'b0;
      ack_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      clk_en_reg <= clk_en_next;
      ack_reg    <= ack_next;
    end
  end

  assign state  = state_reg;
  assign clk_en = clk_en_reg;
  assign ack    = ack_reg;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl with default parameters
// (NUM_REQ=4, WAKE_CYCLES=2, IDLE_CYCLES=8); expectations are hand-computed.
module tb_clk_gate_ctrl;
  import clk_ctrl_pkg::*;

  logic       pclock;
  logic       reset_n;
  logic [3:0] req;
  logic       force_on;
  logic [3:0] ack;
  logic       clk_en;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  clk_gate_ctrl #(
    .NUM_REQ     (4),
    .WAKE_CYCLES (2),
    .IDLE_CYCLES (8)
  ) dut (
    .pclock   (pclock),
    .reset_n  (reset_n),
    .req      (req),
    .force_on (force_on),
    .ack      (ack),
    .clk_en   (clk_en),
    .state    (state)
  );

  initial pclock = 1'b0;
  always #5 pclock = ~pclock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are observed 1ns after it, inputs changed there too.
  task automatic step();
    @(posedge pclock);
    #1;
    $display("t=%0t req=%b force_on=%b state=%0d clk_en=%b ack=%b",
             $time, req, force_on, state, clk_en, ack);
    check("inv_ack_implies_en", {31'd0, (ack != 4'd0) && !clk_en}, 32'd0);
  endtask

  task automatic expect_out(input string tag, input logic [1:0] st,
                            input logic en, input logic [3:0] a);
    check({tag, "_state"}, {30'd0, state}, {30'd0, st});
    check({tag, "_clk_en"}, {31'd0, clk_en}, {31'd0, en});
    check({tag, "_ack"}, {28'd0, ack}, {28'd0, a});
  endtask

  // Drop all demand and let the idle hysteresis run out from ON.
  task automatic drain(input string tag);
    req      = 4'd0;
    force_on = 1'b0;
    for (int i = 0; i < 9; i++) step();
    expect_out(tag, OFF, 1'b0, 4'd0);
  endtask

  initial begin
    reset_n  = 1'b0;
    req      = 4'd0;
    force_on = 1'b0;
    step();
    step();
    expect_out("reset", OFF, 1'b0, 4'd0);
    reset_n = 1'b1;
    step();
    expect_out("post_reset_idle", OFF, 1'b0, 4'd0);

    // Cold wake: req[0] sampled at edge E
    req = 4'b0001;
    step();
    expect_out("wake_E", WAKE, 1'b1, 4'd0);
    step();
    expect_out("wake_E1", WAKE, 1'b1, 4'd0);
    step();
    expect_out("wake_E2", ON, 1'b1, 4'b0001);

    // Overlapping requesters in ON
    req = 4'b1001;
    step();
    expect_out("overlap_add", ON, 1'b1, 4'b1001);
    req = 4'b1000;
    step();
    expect_out("overlap_drop", ON, 1'b1, 4'b1000);

    // Idle timeout: demand falls, sampled at edge K
    req = 4'b0000;
    step();
    expect_out("idle_K", IDLE, 1'b1, 4'd0);
    for (int i = 1; i <= 7; i++) begin
      step();
      expect_out($sformatf("idle_K%0d", i), IDLE, 1'b1, 4'd0);
    end
    step();
    expect_out("idle_K8", OFF, 1'b0, 4'd0);

    // IDLE re-request: get to ON, drop at K, raise req[2] for edge K+5
    req = 4'b0001;
    step();
    step();
    step();
    expect_out("rereq_on", ON, 1'b1, 4'b0001);
    req = 4'b0000;
    step();
    expect_out("rereq_K", IDLE, 1'b1, 4'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      expect_out($sformatf("rereq_K%0d", i), IDLE, 1'b1, 4'd0);
    end
    req = 4'b0100;
    step();
    expect_out("rereq_K5", ON, 1'b1, 4'b0100);
    step();
    expect_out("rereq_K6", ON, 1'b1, 4'b0100);
    drain("rereq_drain");

    // Reset mid-WAKE, then full WAKE re-runs with req held
    req = 4'b0001;
    step();
    expect_out("rstwake_E", WAKE, 1'b1, 4'd0);
    reset_n = 1'b0;
    step();
    expect_out("rstwake_reset", OFF, 1'b0, 4'd0);
    reset_n = 1'b1;
    step();
    expect_out("rstwake_E", WAKE, 1'b1, 4'd0);
    step();
    expect_out("rstwake_E1", WAKE, 1'b1, 4'd0);
    step();
    expect_out("rstwake_E2", ON, 1'b1, 4'b0001);
    drain("rstwake_drain");

    // force_on alone: clock stays on, no ack ever
    force_on = 1'b1;
    step();
    expect_out("force_E", WAKE, 1'b1, 4'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      check("force_clk_en", {31'd0, clk_en}, 32'd1);
      check("force_ack", {28'd0, ack}, 32'd0);
    end
    expect_out("force_hold", ON, 1'b1, 4'd0);
    drain("force_drain");

    // One-cycle req pulse in OFF: WAKE, ON, IDLE, OFF with no ack
    req = 4'b0001;
    step();
    expect_out("pulse_E", WAKE, 1'b1, 4'd0);
    req = 4'b0000;
    step();
    expect_out("pulse_E1", WAKE, 1'b1, 4'd0);
    step();
    expect_out("pulse_E2", ON, 1'b1, 4'd0);
    step();
    expect_out("pulse_E3", IDLE, 1'b1, 4'd0);
    for (int i = 4; i <= 10; i++) begin
      step();
      expect_out($sformatf("pulse_E%0d", i), IDLE, 1'b1, 4'd0);
    end
    step();
    expect_out("pulse_E11", OFF, 1'b0, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
